// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, phase codes and rotation order used by the light
// generator and the monitor.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        PH_RED       = 2'd0,
        PH_RED_AMBER = 2'd1,
        PH_GREEN     = 2'd2,
        PH_AMBER     = 2'd3
    } phase_e;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } trk_state_e;

    localparam logic [2:0] LIGHT_RED       = 3'b100;
    localparam logic [2:0] LIGHT_RED_AMBER = 3'b110;
    localparam logic [2:0] LIGHT_GREEN     = 3'b001;
    localparam logic [2:0] LIGHT_AMBER     = 3'b010;

    function automatic phase_e phase_succ(input phase_e p);
        phase_e s;
        case (p)
            PH_RED:       s = PH_RED_AMBER;
            PH_RED_AMBER: s = PH_GREEN;
            PH_GREEN:     s = PH_AMBER;
            default:      s = PH_RED;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_decode.sv
// Combinational lamp-code decoder: maps the 3-bit lamp pattern to a phase
// and flags whether the pattern is one of the four legal codes.
module tl_light_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] light,
    output logic [1:0] phase,
    output logic       valid
);

    always_comb begin
        phase = PH_RED;
        valid = 1'b1;
        case (light)
            LIGHT_RED:       phase = PH_RED;
            LIGHT_RED_AMBER: phase = PH_RED_AMBER;
            LIGHT_GREEN:     phase = PH_GREEN;
            LIGHT_AMBER:     phase = PH_AMBER;
            default:         valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: tracks the observed lamp phase, flags
// illegal codes, out-of-order transitions and dwell overruns, counts rotations.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MAX_DWELL = 64,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    output logic [1:0]       phase,
    output logic             code_err,
    output logic             seq_err,
    output logic             dwell_err,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             err_sticky
);

    localparam int DW = $clog2(MAX_DWELL + 2);
    localparam logic [DW-1:0] DWELL_SAT = DW'(MAX_DWELL + 1);

    logic [1:0]       dec_phase;
    logic             dec_valid;

    trk_state_e       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;
    logic             dwell_err_q, dwell_err_d;
    logic             cycle_done_q, cycle_done_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             err_sticky_q, err_sticky_d;

    tl_light_decode u_decode (
        .light (light),
        .phase (dec_phase),
        .valid (dec_valid)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        code_err_d   = 1'b0;
        seq_err_d    = 1'b0;
        dwell_err_d  = 1'b0;
        cycle_done_d = 1'b0;
        cycle_cnt_d  = cycle_cnt_q;

        if (!dec_valid) begin
            // Illegal code: keep the last good phase and resynchronise.
            code_err_d = 1'b1;
            dwell_d    = '0;
            state_d    = ST_SYNC;
        end else if (state_q == ST_SYNC) begin
            phase_d = dec_phase;
            dwell_d = DW'(1);
            state_d = ST_TRACK;
        end else if (dec_phase == phase_q) begin
            // Saturating count; the overrun fires only on the step into saturation.
            if (dwell_q < DWELL_SAT) begin
                dwell_d     = dwell_q + DW'(1);
                dwell_err_d = (dwell_q + DW'(1)) == DWELL_SAT;
            end
        end else if (dec_phase == phase_succ(phase_e'(phase_q))) begin
            phase_d = dec_phase;
            dwell_d = DW'(1);
            if (phase_q == PH_AMBER) begin
                cycle_done_d = 1'b1;
                cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
            end
        end else begin
            seq_err_d = 1'b1;
            phase_d   = dec_phase;
            dwell_d   = DW'(1);
        end

        err_sticky_d = err_sticky_q | code_err_d | seq_err_d | dwell_err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            phase_q      <= PH_RED;
            dwell_q      <= '0;
            code_err_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            dwell_err_q  <= 1'b0;
            cycle_done_q <= 1'b0;
            cycle_cnt_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            code_err_q   <= code_err_d;
            seq_err_q    <= seq_err_d;
            dwell_err_q  <= dwell_err_d;
            cycle_done_q <= cycle_done_d;
            cycle_cnt_q  <= cycle_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign phase      = phase_q;
    assign code_err   = code_err_q;
    assign seq_err    = seq_err_q;
    assign dwell_err  = dwell_err_q;
    assign cycle_done = cycle_done_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor with a small dwell limit and a
// narrow rotation counter so saturation and wrap are reachable quickly.
module tb_traffic_light_monitor;

    localparam int MAX_DWELL = 4;
    localparam int CNT_W     = 2;

    typedef struct {
        int phase;
        int code_err;
        int seq_err;
        int dwell_err;
        int cycle_done;
        int cnt;
        int sticky;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       light = 3'b000;
    logic [1:0]       phase;
    logic             code_err, seq_err, dwell_err, cycle_done, err_sticky;
    logic [CNT_W-1:0] cycle_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t sb_q[$];

    // reference model state
    int m_sync = 1, m_phase = 0, m_dwell = 0, m_cnt = 0, m_sticky = 0;

    traffic_light_monitor #(.MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .light      (light),
        .phase      (phase),
        .code_err   (code_err),
        .seq_err    (seq_err),
        .dwell_err  (dwell_err),
        .cycle_done (cycle_done),
        .cycle_cnt  (cycle_cnt),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lamp_phase(input logic [2:0] l);
        if (l == 3'b100) return 0;
        if (l == 3'b110) return 1;
        if (l == 3'b001) return 2;
        if (l == 3'b010) return 3;
        return -1;
    endfunction

    task automatic model(input logic [2:0] l, input logic r, output exp_t e);
        int p;
        e = '{default: 0};
        p = lamp_phase(l);
        if (r) begin
            m_sync = 1; m_phase = 0; m_dwell = 0; m_cnt = 0; m_sticky = 0;
        end else if (p < 0) begin
            e.code_err = 1; m_sync = 1; m_dwell = 0;
        end else if (m_sync == 1) begin
            m_sync = 0; m_phase = p; m_dwell = 1;
        end else if (p == m_phase) begin
            if (m_dwell <= MAX_DWELL) begin
                m_dwell++;
                if (m_dwell == MAX_DWELL + 1) e.dwell_err = 1;
            end
        end else if (p == (m_phase + 1) % 4) begin
            if (m_phase == 3) begin
                e.cycle_done = 1;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            m_phase = p; m_dwell = 1;
        end else begin
            e.seq_err = 1; m_phase = p; m_dwell = 1;
        end
        if (!r && (e.code_err | e.seq_err | e.dwell_err) != 0) m_sticky = 1;
        e.phase = m_phase; e.cnt = m_cnt; e.sticky = m_sticky;
    endtask

    // Drive one sample (inputs set on the falling edge), then compare after the edge.
    task automatic step(input logic [2:0] l, input logic r);
        exp_t e;
        light = l;
        rst   = r;
        model(l, r, e);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("phase",      int'(phase),      e.phase);
        chk("code_err",   int'(code_err),   e.code_err);
        chk("seq_err",    int'(seq_err),    e.seq_err);
        chk("dwell_err",  int'(dwell_err),  e.dwell_err);
        chk("cycle_done", int'(cycle_done), e.cycle_done);
        chk("cycle_cnt",  int'(cycle_cnt),  e.cnt);
        chk("err_sticky", int'(err_sticky), e.sticky);
    endtask

    task automatic rotation();
        step(3'b110, 1'b0);
        step(3'b001, 1'b0);
        step(3'b010, 1'b0);
        step(3'b100, 1'b0);
    endtask

    int n_done;

    initial begin
        @(negedge clk);
        step(3'b111, 1'b1);
        step(3'b001, 1'b1);
        chk("rst_phase", int'(phase), 0);

        // rotation RED..AMBER..RED
        step(3'b100, 1'b0);
        rotation();
        chk("s1_cnt", int'(cycle_cnt), 1);
        chk("s1_done", int'(cycle_done), 1);
        chk("s1_sticky", int'(err_sticky), 0);

        // illegal code while GREEN, then resync on AMBER
        step(3'b110, 1'b0);
        step(3'b001, 1'b0);
        step(3'b111, 1'b0);
        chk("s2_code_err", int'(code_err), 1);
        chk("s2_hold", int'(phase), 2);
        step(3'b010, 1'b0);
        chk("s2_resync", int'(phase), 3);
        chk("s2_no_seq", int'(seq_err), 0);
        chk("s2_sticky", int'(err_sticky), 1);

        // skip and reverse transitions
        step(3'b000, 1'b1);
        step(3'b100, 1'b0);
        step(3'b001, 1'b0);
        chk("s3_skip", int'(seq_err), 1);
        step(3'b110, 1'b0);
        chk("s3_rev_phase", int'(phase), 1);
        chk("s3_rev", int'(seq_err), 1);

        // dwell overrun
        step(3'b000, 1'b1);
        n_done = 0;
        for (int i = 0; i < 7; i++) begin
            step(3'b100, 1'b0);
            if (dwell_err) begin
                n_done++;
                chk("s4_dwell_at", i + 1, 5);
            end
        end
        chk("s4_dwell_once", n_done, 1);
        step(3'b110, 1'b0);
        chk("s4_no_err", int'(seq_err | dwell_err | code_err), 0);

        // counter wrap with four rotations
        step(3'b000, 1'b1);
        step(3'b100, 1'b0);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            rotation();
            n_done += int'(cycle_done);
            chk("s5_cnt", int'(cycle_cnt), (i + 1) % 4);
        end
        chk("s5_done", n_done, 4);

        // reset mid-rotation
        step(3'b110, 1'b0);
        step(3'b001, 1'b0);
        step(3'b001, 1'b1);
        chk("s6_phase", int'(phase), 0);
        chk("s6_cnt", int'(cycle_cnt), 0);
        chk("s6_sticky", int'(err_sticky), 0);
        step(3'b001, 1'b0);
        chk("s6_post", int'(phase), 2);
        chk("s6_no_seq", int'(seq_err), 0);

        // random mix biased toward legal codes and in-order progress
        for (int i = 0; i < 200; i++) begin
            logic [2:0] l;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       l = 3'($urandom_range(0, 7));
                1, 2, 3: l = light;
                default: begin
                    case ((m_phase + 1) % 4)
                        0:       l = 3'b100;
                        1:       l = 3'b110;
                        2:       l = 3'b001;
                        default: l = 3'b010;
                    endcase
                end
            endcase
            step(l, ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter MAX_DWELL, default 64: max consecutive sampled cycles one phase may persist before dwell_err.
REQ-002 SHALL have parameter CNT_W, default 8: width of cycle_cnt.
REQ-003 SHALL have port clk, input, 1: clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port light, input, 3: observed lamp code. 100=RED, 110=RED_AMBER, 001=GREEN, 010=AMBER; all others illegal.
REQ-006 SHALL have port phase, output, 2: decoded phase. 0=RED, 1=RED_AMBER, 2=GREEN, 3=AMBER.
REQ-007 SHALL have port code_err, output, 1: single-cycle pulse on an illegal code.
REQ-008 SHALL have port seq_err, output, 1: single-cycle pulse on an illegal phase transition.
REQ-009 SHALL have port dwell_err, output, 1: single-cycle pulse on a dwell overrun.
REQ-010 SHALL have port cycle_done, output, 1: single-cycle pulse on a completed AMBER->RED rotation.
REQ-011 SHALL have port cycle_cnt, output, CNT_W: count of completed rotations.
REQ-012 SHALL have port err_sticky, output, 1: OR of all error pulses since reset.

Function
REQ-013 SHALL register all outputs. Outputs reflect light sampled at the most recent rising edge (1-cycle latency).
REQ-014 SHALL run a 2-state tracker, SYNC and TRACK; reset enters SYNC.
REQ-015 In SYNC, a legal code SHALL load phase, set dwell=1, enter TRACK, and SHALL raise no seq_err and no cycle_done.
REQ-016 In TRACK, a legal code equal to phase SHALL increment dwell, saturating at MAX_DWELL+1.
REQ-017 In TRACK, a legal code equal to successor(phase) SHALL load phase and set dwell=1. Successor order: RED->RED_AMBER->GREEN->AMBER->RED.
REQ-018 In TRACK, any other legal code (skip or reverse) SHALL pulse seq_err, load phase with the new code, set dwell=1, and stay in TRACK.
REQ-019 An illegal code in any state SHALL pulse code_err, hold phase, and enter SYNC.
REQ-020 dwell_err SHALL pulse exactly once, on the sample where dwell first reaches MAX_DWELL+1. No repeat pulse until phase changes.
REQ-021 The TRACK transition AMBER->RED SHALL pulse cycle_done and increment cycle_cnt. cycle_cnt wraps modulo 2^CNT_W.
REQ-022 err_sticky SHALL set on any code_err, seq_err or dwell_err pulse, and clear only on reset.
REQ-023 Only one of seq_err and code_err can occur per sample. dwell_err and cycle_done are mutually exclusive with seq_err.
REQ-024 The dwell counter SHALL be clog2(MAX_DWELL+2) bits wide and SHALL never wrap.

Reset
REQ-025 While rst=1 at an edge, outputs SHALL become: phase=0 (RED), all pulses=0, cycle_cnt=0, err_sticky=0. Internally: dwell=0, state=SYNC.
REQ-026 light SHALL be ignored on edges where rst=1. rst asserted mid-rotation SHALL abandon tracking with no error pulse.

Structure
REQ-027 Phase codes, the four light encodings and the successor function SHALL reside in shared package traffic_light_pkg, used by the light generator and this monitor.
REQ-028 A combinational sub-module tl_light_decode (light -> phase, valid) SHALL perform decoding. Tracker, counters and flags stay in traffic_light_monitor.

Verification
REQ-029 Scenario 1: reset, then light 100,110,001,010,100 one per cycle -> phase 0,1,2,3,0; exactly one cycle_done (on the final 100 sample); cycle_cnt=1; no error flags.
REQ-030 Scenario 2: in TRACK at GREEN, apply 111 then 010 -> code_err pulse on the 111 sample; phase stays 2; err_sticky=1; the following 010 gives phase=3 with no seq_err (SYNC re-entry).
REQ-031 Scenario 3: sequence 100 then 001 -> seq_err pulse, phase=2. Sequence 001 then 110 (reverse) -> seq_err pulse, phase=1.
REQ-032 Scenario 4: MAX_DWELL=4, hold 100 for 7 cycles -> single dwell_err pulse on the 5th sample; then 110 -> no error; dwell restarts.
REQ-033 Scenario 5: CNT_W=2, four full legal rotations -> cycle_cnt 1,2,3,0; four cycle_done pulses.
REQ-034 Scenario 6: rst asserted one cycle while observing GREEN -> next edge: phase=0, cycle_cnt=0, err_sticky=0. First post-reset sample 001 -> phase=2 with no seq_err.
